// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_pkg
//  Description : Shared constants for the VGA test-pattern generator: mode
//                encodings, colour-bar palette and bouncing-box colours.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pattern_pkg;

    // Pattern selector encodings; values 5..7 fall through to solid white
    localparam logic [2:0] MODE_BARS  = 3'd0;
    localparam logic [2:0] MODE_CHECK = 3'd1;
    localparam logic [2:0] MODE_GRAD  = 3'd2;
    localparam logic [2:0] MODE_BOX   = 3'd3;
    localparam logic [2:0] MODE_GRID  = 3'd4;

    // Colour-bar palette, left to right
    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    // Bouncing-box foreground and the background around it
    localparam logic [23:0] BOX_COLOR = 24'hFF0000;
    localparam logic [23:0] BG_COLOR  = 24'h404040;

    // Map a bar index (0 = leftmost) to its colour
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COLOR_WHITE;
            3'd1:    col = COLOR_YELLOW;
            3'd2:    col = COLOR_CYAN;
            3'd3:    col = COLOR_GREEN;
            3'd4:    col = COLOR_MAGENTA;
            3'd5:    col = COLOR_RED;
            3'd6:    col = COLOR_BLUE;
            default: col = COLOR_BLACK;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ============================================================================
//  Module      : vga_box_mover
//  Description : Position/direction state of the bouncing box. Steps the box
//                once per update strobe (unless paused) and reflects it off
//                the edges of the active area, clamping to the wall.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_box_mover #(
    parameter int HACTIVE  = 800,
    parameter int VACTIVE  = 600,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        pause,
    output logic [10:0] box_x,
    output logic [10:0] box_y
);

    // Bounce limits kept at 12 bits so position+STEP cannot wrap
    localparam logic [11:0] c_x_max  = 12'(HACTIVE - BOX_SIZE);
    localparam logic [11:0] c_y_max  = 12'(VACTIVE - BOX_SIZE);
    localparam logic [11:0] c_step12 = 12'(STEP);
    localparam logic [10:0] c_step11 = 11'(STEP);

    logic [10:0] r_box_x;
    logic [10:0] r_box_y;
    logic        r_dir_x;   // 0 = moving right, 1 = moving left
    logic        r_dir_y;   // 0 = moving down,  1 = moving up

    // Advance both axes once per frame; a wall hit clamps and reverses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_box_x <= 11'd0;
            r_box_y <= 11'd0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (update && !pause) begin
            if (!r_dir_x) begin
                if (({1'b0, r_box_x} + c_step12) > c_x_max) begin
                    r_box_x <= c_x_max[10:0];
                    r_dir_x <= 1'b1;
                end else begin
                    r_box_x <= r_box_x + c_step11;
                end
            end else if ({1'b0, r_box_x} < c_step12) begin
                r_box_x <= 11'd0;
                r_dir_x <= 1'b0;
            end else begin
                r_box_x <= r_box_x - c_step11;
            end

            if (!r_dir_y) begin
                if (({1'b0, r_box_y} + c_step12) > c_y_max) begin
                    r_box_y <= c_y_max[10:0];
                    r_dir_y <= 1'b1;
                end else begin
                    r_box_y <= r_box_y + c_step11;
                end
            end else if ({1'b0, r_box_y} < c_step12) begin
                r_box_y <= 11'd0;
                r_dir_y <= 1'b0;
            end else begin
                r_box_y <= r_box_y - c_step11;
            end
        end
    end

    assign box_x = r_box_x;
    assign box_y = r_box_y;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pattern_gen
//  Description : Test-pattern pixel source for the VGA sync generator. Looks
//                one pixel ahead of hc/vc and registers the colour so the
//                output is pixel-aligned. Mode is latched once per frame.
//                Optional feature macro: VGA_PATTERN_BOX_EN (bouncing box).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int HTOTAL   = 896,
    parameter int VTOTAL   = 625,
    parameter int HACTIVE  = 800,
    parameter int VACTIVE  = 600,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic [2:0]  mode,
    input  logic        pause,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_tick
);

    localparam logic [10:0] c_h_last     = 11'(HTOTAL - 1);
    localparam logic [10:0] c_v_last     = 11'(VTOTAL - 1);
    localparam logic [10:0] c_h_active   = 11'(HACTIVE);
    localparam logic [10:0] c_v_active   = 11'(VACTIVE);
    localparam logic [10:0] c_h_act_last = 11'(HACTIVE - 1);
    localparam logic [10:0] c_v_act_last = 11'(VACTIVE - 1);

    logic [10:0] w_nh;
    logic [10:0] w_nv;
    logic        w_active;
    logic        w_frame_event;
    logic [2:0]  w_bar_idx;
    logic [23:0] w_color;

    logic [23:0] r_rgb;
    logic        r_frame_tick;
    logic [2:0]  r_mode_q;

    // Coordinates of the pixel that will be on screen next cycle
    assign w_nh = (hc == c_h_last) ? 11'd0 : hc + 11'd1;
    assign w_nv = (hc == c_h_last) ? ((vc == c_v_last) ? 11'd0 : vc + 11'd1) : vc;

    assign w_active      = (w_nh < c_h_active) && (w_nv < c_v_active);
    assign w_frame_event = (w_nh == 11'd0) && (w_nv == c_v_active);

    // Bar index from constant thresholds, avoiding a runtime divide
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_nh >= 11'(k * (HACTIVE / 8))) begin
                w_bar_idx = 3'(k);
            end
        end
    end

`ifdef VGA_PATTERN_BOX_EN
    logic [10:0] w_box_x;
    logic [10:0] w_box_y;
    logic        w_in_box;

    vga_box_mover #(
        .HACTIVE  (HACTIVE),
        .VACTIVE  (VACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box_mover (
        .clk    (clk),
        .rst    (rst),
        .update (w_frame_event),
        .pause  (pause),
        .box_x  (w_box_x),
        .box_y  (w_box_y)
    );

    // Box extent compared at 12 bits so box+BOX_SIZE never wraps
    assign w_in_box = (w_nh >= w_box_x)
                   && ({1'b0, w_nh} < ({1'b0, w_box_x} + 12'(BOX_SIZE)))
                   && (w_nv >= w_box_y)
                   && ({1'b0, w_nv} < ({1'b0, w_box_y} + 12'(BOX_SIZE)));
`else
    // Box motion does not exist in this build, so pause has no consumer
    logic w_unused_pause;
    assign w_unused_pause = pause;
`endif

    // Colour of the upcoming pixel for the latched pattern
    always_comb begin
        w_color = COLOR_WHITE;
        case (r_mode_q)
            MODE_BARS:  w_color = bar_color(w_bar_idx);
            MODE_CHECK: w_color = (w_nh[5] ^ w_nv[5]) ? COLOR_WHITE : COLOR_BLACK;
            MODE_GRAD:  w_color = {w_nh[7:0], w_nh[7:0], w_nh[7:0]};
`ifdef VGA_PATTERN_BOX_EN
            MODE_BOX:   w_color = w_in_box ? BOX_COLOR : BG_COLOR;
`else
            MODE_BOX:   w_color = bar_color(w_bar_idx);
`endif
            MODE_GRID:  w_color = ((w_nh[5:0] == 6'd0) || (w_nv[5:0] == 6'd0) ||
                                   (w_nh == c_h_act_last) || (w_nv == c_v_act_last))
                                  ? COLOR_WHITE : COLOR_BLACK;
            default:    w_color = COLOR_WHITE;
        endcase
    end

    // Register colour, frame pulse and once-per-frame mode latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb        <= 24'd0;
            r_frame_tick <= 1'b0;
            r_mode_q     <= MODE_BARS;
        end else begin
            r_rgb        <= w_active ? w_color : 24'd0;
            r_frame_tick <= w_frame_event;
            if (w_frame_event) begin
                r_mode_q <= mode;
            end
        end
    end

    assign r          = r_rgb[23:16];
    assign g          = r_rgb[15:8];
    assign b          = r_rgb[7:0];
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pattern_gen
//  Description : Self-checking bench for vga_pattern_gen. Table of pixel
//                vectors plus hand-written reset, mode-latch and box cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    logic        clk;
    logic        rst;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [2:0]  mode;
    logic        pause;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        frame_tick;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          h;
        int          v;
        logic [2:0]  md;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    vga_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .mode       (mode),
        .pause      (pause),
        .r          (r),
        .g          (g),
        .b          (b),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %06h expected %06h", name, act, exp);
    endtask

    // Drive the counter value one before (h,v) so pixel (h,v) is shown next
    task automatic probe(input int h, input int v);
        if (h == 0) begin
            hc = 11'd895;
            vc = (v == 0) ? 11'd624 : 11'(v - 1);
        end else begin
            hc = 11'(h - 1);
            vc = 11'(v);
        end
        tick();
    endtask

    task automatic frame_event();
        hc = 11'd895;
        vc = 11'd599;
        tick();
    endtask

    task automatic check_px(input int h, input int v, input logic [23:0] exp);
        probe(h, v);
        check($sformatf("pix(%0d,%0d)", h, v), {r, g, b}, exp);
    endtask

    initial begin
        logic [2:0] cur_mode;

        rst = 1'b1; hc = 11'd300; vc = 11'd100; mode = 3'd0; pause = 1'b0;

        // Pixel table: {h, v, mode, expected colour}
        vecs.push_back('{ 99,  10, 3'd0, 24'hFFFFFF});
        vecs.push_back('{100,  10, 3'd0, 24'hFFFF00});
        vecs.push_back('{250,  10, 3'd0, 24'h00FFFF});
        vecs.push_back('{350,  10, 3'd0, 24'h00FF00});
        vecs.push_back('{450,  10, 3'd0, 24'hFF00FF});
        vecs.push_back('{550,  10, 3'd0, 24'hFF0000});
        vecs.push_back('{650,  10, 3'd0, 24'h0000FF});
        vecs.push_back('{799,  10, 3'd0, 24'h000000});
        vecs.push_back('{800,  10, 3'd0, 24'h000000});
        vecs.push_back('{ 10, 599, 3'd0, 24'hFFFFFF});
        vecs.push_back('{ 10, 600, 3'd0, 24'h000000});
        vecs.push_back('{  0,   0, 3'd0, 24'hFFFFFF});
        vecs.push_back('{  0,  11, 3'd0, 24'hFFFFFF});
        vecs.push_back('{  0, 600, 3'd0, 24'h000000});
        vecs.push_back('{ 32,   0, 3'd1, 24'hFFFFFF});
        vecs.push_back('{ 40,  40, 3'd1, 24'h000000});
        vecs.push_back('{ 10,  40, 3'd1, 24'hFFFFFF});
        vecs.push_back('{ 10,  10, 3'd1, 24'h000000});
        vecs.push_back('{300,   5, 3'd2, 24'h2C2C2C});
        vecs.push_back('{255,   0, 3'd2, 24'hFFFFFF});
        vecs.push_back('{128,  50, 3'd2, 24'h808080});
        vecs.push_back('{  0, 100, 3'd2, 24'h000000});
        vecs.push_back('{ 64,  10, 3'd4, 24'hFFFFFF});
        vecs.push_back('{ 65,  10, 3'd4, 24'h000000});
        vecs.push_back('{ 65, 128, 3'd4, 24'hFFFFFF});
        vecs.push_back('{799,  10, 3'd4, 24'hFFFFFF});
        vecs.push_back('{798, 599, 3'd4, 24'hFFFFFF});
        vecs.push_back('{798, 598, 3'd4, 24'h000000});
        vecs.push_back('{ 10,  10, 3'd5, 24'hFFFFFF});
        vecs.push_back('{ 10, 600, 3'd5, 24'h000000});
        vecs.push_back('{700, 300, 3'd7, 24'hFFFFFF});

        // Reset state, then asynchronous reset assertion mid-line
        tick(); tick();
        check("reset_rgb", {r, g, b}, 24'h000000);
        check("reset_tick", {23'd0, frame_tick}, 24'd0);
        rst = 1'b0;
        check_px(150, 10, 24'hFFFF00);
        #2 rst = 1'b1;
        #1 check("async_reset_rgb", {r, g, b}, 24'h000000);
        check("async_reset_tick", {23'd0, frame_tick}, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        hc = 11'd0; vc = 11'd0;
        tick();
        check("after_reset_rgb", {r, g, b}, 24'hFFFFFF);

        // Table-driven pixel vectors; a mode change costs one frame event
        cur_mode = 3'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].md != cur_mode) begin
                mode = vecs[i].md;
                frame_event();
                cur_mode = vecs[i].md;
            end
            check_px(vecs[i].h, vecs[i].v, vecs[i].exp);
        end

        // Mode change mid-frame only takes effect after the frame event
        mode = 3'd0;
        frame_event();
        mode = 3'd2;
        check_px(400, 300, 24'hFF00FF);
        check_px(500, 300, 24'hFF0000);
        hc = 11'd894; vc = 11'd599; tick();
        check("tick_before_event", {23'd0, frame_tick}, 24'd0);
        hc = 11'd895; vc = 11'd599; tick();
        check("tick_on_event", {23'd0, frame_tick}, 24'd1);
        hc = 11'd0; vc = 11'd600; tick();
        check("tick_one_cycle", {23'd0, frame_tick}, 24'd0);
        check_px(300, 5, 24'h2C2C2C);

`ifdef VGA_PATTERN_BOX_EN
        // Fresh box at (0,0); 25 frames put it at (50,50)
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 3'd3;
        repeat (25) frame_event();
        check_px(49, 50, 24'h404040);
        check_px(50, 50, 24'hFF0000);
        check_px(81, 50, 24'hFF0000);
        check_px(82, 50, 24'h404040);
        check_px(50, 49, 24'h404040);
        check_px(50, 81, 24'hFF0000);
        check_px(50, 82, 24'h404040);

        // Paused frames still pulse frame_tick but leave the box in place
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_event();
            check($sformatf("pause_tick%0d", i), {23'd0, frame_tick}, 24'd1);
        end
        check_px(50, 50, 24'hFF0000);
        check_px(49, 50, 24'h404040);
        pause = 1'b0;

        // 383 moving frames: x=766 heading right; y bounced at 568, now 372
        repeat (358) frame_event();
        check_px(766, 372, 24'hFF0000);
        check_px(765, 372, 24'h404040);
        // 766+2 does not exceed 768: moves to the wall, still heading right
        frame_event();
        check_px(768, 370, 24'hFF0000);
        check_px(767, 370, 24'h404040);
        check_px(799, 370, 24'hFF0000);
        // 768+2 exceeds the limit: clamps at 768 and turns left
        frame_event();
        check_px(768, 368, 24'hFF0000);
        check_px(767, 368, 24'h404040);
        // Now moving left
        frame_event();
        check_px(766, 366, 24'hFF0000);
        check_px(797, 366, 24'hFF0000);
        check_px(798, 366, 24'h404040);
`else
        // Without the box feature mode 3 renders colour bars; pause is ignored
        mode = 3'd3;
        pause = 1'b1;
        frame_event();
        check_px(150, 10, 24'hFFFF00);
        check_px(450, 10, 24'hFF00FF);
        pause = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
